// File: rtl/hilo_mdu_ctrl.sv
// HI/LO sequencer: owns the multi-cycle multiply/divide unit and funnels every HI/LO
// update (MULT/DIV results and MTHI/MTLO) through one registered write port.
module hilo_mdu_ctrl #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] opa_i,
    input  logic [DATA_W-1:0] opb_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              hilo_we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_ON,
        S_DIV_ZERO,
        S_DIV_ON,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sgn_q, sgn_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quot_q, quot_d;
    logic                q_neg_q, q_neg_d;
    logic                r_neg_q, r_neg_d;
    logic                hilo_we_q, hilo_we_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic [2*DATA_W-1:0] a_ext, b_ext, product;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;
    logic [DATA_W-1:0]   rem_step, quot_step;
    logic                op_is_div_s;
    logic [DATA_W-1:0]   a_mag, b_mag;

    // One multiplier serves both flavours: sign- or zero-extend to 2W, keep low 2W bits.
    always_comb begin
        a_ext   = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
        b_ext   = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
        product = a_ext * b_ext;
    end

    // Restoring divider step: partial remainder always stays below the divisor magnitude.
    always_comb begin
        div_shift = {rem_q, quot_q[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        rem_step  = div_ge ? (div_shift[DATA_W-1:0] - b_q) : div_shift[DATA_W-1:0];
        quot_step = {quot_q[DATA_W-2:0], div_ge};
    end

    always_comb begin
        op_is_div_s = (op_i == OP_DIV);
        a_mag       = (op_is_div_s && opa_i[DATA_W-1]) ? -opa_i : opa_i;
        b_mag       = (op_is_div_s && opb_i[DATA_W-1]) ? -opb_i : opb_i;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        hilo_we_d = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    case (op_i)
                        OP_MULT, OP_MULTU: begin
                            a_d     = opa_i;
                            b_d     = opb_i;
                            sgn_d   = (op_i == OP_MULT);
                            cnt_d   = '0;
                            state_d = S_MUL_ON;
                        end
                        OP_DIV, OP_DIVU: begin
                            quot_d  = a_mag;
                            b_d     = b_mag;
                            rem_d   = '0;
                            q_neg_d = op_is_div_s & (opa_i[DATA_W-1] ^ opb_i[DATA_W-1]);
                            r_neg_d = op_is_div_s & opa_i[DATA_W-1];
                            cnt_d   = '0;
                            state_d = (opb_i == '0) ? S_DIV_ZERO : S_DIV_ON;
                        end
                        OP_MTHI: begin
                            hi_d      = opa_i;
                            lo_d      = lo_i;
                            hilo_we_d = 1'b1;
                            state_d   = S_DONE;
                        end
                        OP_MTLO: begin
                            hi_d      = hi_i;
                            lo_d      = opa_i;
                            hilo_we_d = 1'b1;
                            state_d   = S_DONE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_MUL_ON: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
                    hi_d      = product[2*DATA_W-1:DATA_W];
                    lo_d      = product[DATA_W-1:0];
                    hilo_we_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV_ZERO: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d      = '0;
                    lo_d      = '0;
                    hilo_we_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DIV_ON: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d  = rem_step;
                    quot_d = quot_step;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        // Signs are restored on the final step so the write lands in DONE.
                        lo_d      = q_neg_q ? -quot_step : quot_step;
                        hi_d      = r_neg_q ? -rem_step : rem_step;
                        hilo_we_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            hilo_we_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            hilo_we_q <= hilo_we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // A flush arriving in DONE still has to cancel the write that is already staged.
    assign hilo_we_o = hilo_we_q & ~flush_i;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign busy_o    = (state_q != S_IDLE);
    assign stall_o   = ((state_q == S_IDLE) && start_i && !flush_i &&
                        (op_i >= OP_MULT) && (op_i <= OP_DIVU)) ||
                       (state_q == S_MUL_ON) || (state_q == S_DIV_ZERO) ||
                       (state_q == S_DIV_ON);

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Scoreboard bench for hilo_mdu_ctrl: stimulus pushes expected writes, a monitor pops
// and compares them whenever hilo_we_o fires.
module tb_hilo_mdu_ctrl;
    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rst, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] opa_i, opb_i, hi_i, lo_i;
    logic        stall_o, busy_o, hilo_we_o;
    logic [31:0] hi_o, lo_o;

    hilo_mdu_ctrl #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .hi_i(hi_i), .lo_i(lo_i),
        .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o),
        .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural meaning of each op.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hin, input logic [31:0] lin,
                                  output logic we, output logic st, output logic [31:0] eh,
                                  output logic [31:0] el, output int lat);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        we = 1'b1; st = 1'b0; eh = '0; el = '0; lat = 0;
        case (op)
            3'd1: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; st = 1'b1; lat = MUL_LAT + 1; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; st = 1'b1; lat = MUL_LAT + 1; end
            3'd3: begin
                st = 1'b1;
                if (b == 0) begin lat = 2; end
                else begin
                    sq = sa / sb; sr = sa % sb;
                    el = sq[31:0]; eh = sr[31:0]; lat = DATA_W + 1;
                end
            end
            3'd4: begin
                st = 1'b1;
                if (b == 0) begin lat = 2; end
                else begin el = a / b; eh = a % b; lat = DATA_W + 1; end
            end
            3'd5: begin eh = a; el = lin; lat = 1; end
            3'd6: begin eh = hin; el = a; lat = 1; end
            default: begin we = 1'b0; lat = 0; end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && hilo_we_o) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_write at cycle %0d: got hilo_we_o=1 hi=%0h lo=%0h, required no write",
                         cyc, hi_o, lo_o);
            end else begin
                mon_e = sb_q.pop_front();
                chk("write_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("write_hi", hi_o, mon_e.hi);
                chk("write_lo", lo_o, mon_e.lo);
            end
        end
    end

    task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] hin, input logic [31:0] lin);
        start_i = 1'b1; op_i = op; opa_i = a; opb_i = b; hi_i = hin; lo_i = lin; flush_i = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hin, input logic [31:0] lin, input bit garbage);
        logic        we, st;
        logic [31:0] eh, el;
        int          lat;
        exp_t        e;
        model(op, a, b, hin, lin, we, st, eh, el, lat);
        @(posedge clk); #1;
        drive_start(op, a, b, hin, lin);
        if (we) begin
            e.cyc = cyc + lat; e.hi = eh; e.lo = el;
            sb_q.push_back(e);
        end
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            chk("stall", stall_o, st && (i < lat));
            chk("busy", busy_o, i > 0);
            @(posedge clk); #1;
            if (garbage && (i + 1 < lat))
                drive_start(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom);
            else
                start_i = 1'b0;
        end
        if (we) begin
            chk("sb_drained", 64'(sb_q.size()), 64'd0);
            chk("hold_hi", hi_o, eh);
            chk("hold_lo", lo_o, el);
            chk("we_one_cycle", hilo_we_o, 1'b0);
        end
    endtask

    task automatic issue_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int foff);
        @(posedge clk); #1;
        drive_start(op, a, b, $urandom, $urandom);
        flush_i = (foff == 0);
        for (int i = 0; i < foff; i++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            flush_i = (i + 1 == foff);
        end
        @(negedge clk);
        chk("flush_no_we", hilo_we_o, 1'b0);
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy_o, 1'b0);
        chk("flush_stall", stall_o, 1'b0);
        chk("flush_we_after", hilo_we_o, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic        we, st;
        logic [31:0] eh, el, a, b;
        logic [2:0]  op;
        int          lat, r;

        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
        opa_i = '0; opb_i = '0; hi_i = '0; lo_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_we", hilo_we_o, 1'b0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);

        issue(3'd3, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 1'b0);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0);
        issue(3'd4, 32'd100, 32'd0, 32'd0, 32'd0, 1'b0);
        issue_flush(3'd4, 32'd100, 32'd7, 10);
        issue(3'd4, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
        issue(3'd5, 32'h12345678, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h0000ABCD, 1'b0);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1);
        issue(3'd3, 32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 1'b1);
        issue(3'd6, 32'hCAFEF00D, 32'd0, 32'h11112222, 32'h33334444, 1'b0);
        issue(3'd0, 32'h1, 32'h2, 32'd0, 32'd0, 1'b0);
        issue(3'd7, 32'h1, 32'h2, 32'd0, 32'd0, 1'b0);
        issue_flush(3'd1, 32'd3, 32'd5, 0);
        issue_flush(3'd2, 32'd3, 32'd5, MUL_LAT + 1);
        issue_flush(3'd5, 32'd9, 32'd0, 1);
        issue_flush(3'd3, 32'd9, 32'd0, 1);
        issue(3'd1, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd0, 1'b1);

        // Reset in the middle of a divide must leave nothing pending.
        @(posedge clk); #1;
        drive_start(3'd3, 32'd1000, 32'd3, 32'd0, 32'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_stall", stall_o, 1'b0);
        chk("midrst_we", hilo_we_o, 1'b0);
        chk("midrst_hi", hi_o, 32'd0);
        chk("midrst_lo", lo_o, 32'd0);
        repeat (DATA_W + 4) @(posedge clk);

        for (int n = 0; n < 48; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            else if (r == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (r == 2) b = 32'($urandom_range(1, 15));
            else if (r == 3) b = -32'($urandom_range(1, 15));
            model(op, a, b, 32'd0, 32'd0, we, st, eh, el, lat);
            if (we && $urandom_range(0, 6) == 0)
                issue_flush(op, a, b, $urandom_range(0, lat));
            else
                issue(op, a, b, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
